display_driver_multi: RTL
=========================

// Module: display_driver_multi
// PURPOSE
//  Parametrised successor of the single-digit display driver. Chooses alarm, key-buffer or current time, converts
//  each BCD digit to ASCII and streams the characters to the LCD controller over a valid/ready handshake. Also runs
//  a registered alarm state machine (edge-triggered ring, acknowledge, timeout) and blinks digits in set mode.
//  Sits between the time/alarm/key-buffer registers and the LCD character interface.
// PARAMETERS
//  NUM_DIGITS  4   BCD digits per time value (>=1); digit NUM_DIGITS-1 is most significant
//  RING_SECS   60  one_second ticks before an unacknowledged alarm self-silences (>=1)
// PORTS
//  clock            in   1              system clock, all state on rising edge
//  reset            in   1              synchronous, active-high
//  one_second       in   1              1-cycle tick, once per second
//  show_a           in   1              display alarm_time (highest priority)
//  show_new_time    in   1              display key_buffer_time (blinking)
//  alarm_enable     in   1              arms alarm comparison
//  alarm_off        in   1              1-cycle acknowledge: silences ringing alarm
//  current_time     in   4*NUM_DIGITS   packed BCD, digit i at [4i+3:4i]
//  alarm_time       in   4*NUM_DIGITS   packed BCD
//  key_buffer_time  in   4*NUM_DIGITS   packed BCD
//  char_ready       in   1              LCD controller accepts char_data
//  char_valid       out  1              char_data/char_pos valid
//  char_data        out  8              ASCII character
//  char_pos         out  clog2(NUM_DIGITS) max 1   column index, 0 = most significant digit
//  frame_done       out  1              1-cycle pulse after last char of a frame accepted
//  sound_alarm      out  1              registered alarm output
// BEHAVIOUR
//  Reset: every output is 0; frame FSM=IDLE, alarm FSM=A_IDLE, blink_phase=1, tick counter=0.
//  Frame FSM: IDLE -> LOAD (1 cycle) -> SEND -> DONE -> LOAD ...
//   LOAD: snapshot the source vector (show_a ? alarm : show_new_time ? key_buffer : current) and the blank flag
//     (show_new_time & ~show_a & ~blink_phase); set pos=0.
//   SEND: char_valid=1. A char is accepted on a cycle with char_valid&char_ready. After acceptance pos increments.
//     Accepting pos=NUM_DIGITS-1 -> DONE. char_data/char_pos stay stable while valid&~ready. Mode changes
//     mid-frame do not affect the current frame.
//   DONE: char_valid=0, frame_done=1 for exactly that cycle, then LOAD.
//  First char_valid appears 2 cycles after reset is released. With ready held at 1, one frame takes NUM_DIGITS+2 cycles.
//  Encoding per digit d: 0-9 -> 8'h30+d; 10-15 -> 8'h3A (error); when the blank flag is set, every digit -> 8'h20.
//  blink_phase toggles on each one_second; it is forced to 1 while show_new_time=0.
//  match = alarm_enable & (current_time == alarm_time), compared over the full vector and registered as match_q.
//  Alarm FSM (sound_alarm=1 only in A_RING):
//   A_IDLE -> A_RING on match & ~match_q (rising edge only; a match already present at arm time also counts).
//   A_RING -> A_HOLD on alarm_off, or when the tick counter reaches RING_SECS (counts one_second, cleared on entry).
//   A_HOLD -> A_IDLE when match=0; an alarm is never re-triggered during the same matching period.
//   Any state -> A_IDLE when alarm_enable=0 (priority over alarm_off and timeout).
//  alarm_off and timeout in the same cycle -> A_HOLD. Counter saturates and does not wrap.
//  Reset asserted mid-frame or mid-ring: the next edge returns to the reset values; the partial frame is dropped,
//  not resumed.
// STRUCTURE
//  Shared package display_pkg: ASCII constants (ZERO..NINE, ERROR=8'h3A, BLANK=8'h20), frame and alarm state
//  encodings, function bcd_to_ascii(4-bit) -> 8-bit.
//  One sub-module: alarm_ctrl (match register, alarm FSM, ring counter). Frame FSM and blink stay in the top level.
// TESTING
//  1 NUM_DIGITS=4, current=16'h1234, ready=1 -> chars 31,32,33,34 at pos 0..3 on consecutive cycles, then
//    frame_done for 1 cycle.
//  2 Backpressure: ready low 3 cycles at pos 1 -> char_data=8'h32 and pos=1 held stable, no skip or duplicate.
//  3 show_a=1 and show_new_time=1, alarm=16'h0700 -> frame 30,37,30,30. Digit 4'hB -> 8'h3A.
//  4 show_new_time=1, key=16'h0945 -> frames alternate between 30,39,34,35 and four 8'h20 on each one_second.
//  5 alarm_enable=1, current steps to equal alarm -> sound_alarm=1 one cycle after match. alarm_off -> 0 next
//    cycle and stays 0 until current changes. RING_SECS=3 without ack -> clears after 3rd tick.
//  6 reset pulse mid-frame (pos=2) and mid-ring -> all outputs 0 next cycle, new frame restarts at pos 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, state encodings and BCD-to-ASCII conversion for the display driver.
package display_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ONE   = 8'h31;
    localparam logic [7:0] ASCII_TWO   = 8'h32;
    localparam logic [7:0] ASCII_THREE = 8'h33;
    localparam logic [7:0] ASCII_FOUR  = 8'h34;
    localparam logic [7:0] ASCII_FIVE  = 8'h35;
    localparam logic [7:0] ASCII_SIX   = 8'h36;
    localparam logic [7:0] ASCII_SEVEN = 8'h37;
    localparam logic [7:0] ASCII_EIGHT = 8'h38;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_ERROR = 8'h3A;
    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic [1:0] {F_IDLE, F_LOAD, F_SEND, F_DONE} frame_state_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_HOLD} alarm_state_t;

    // Valid BCD digits map to '0'..'9'; codes 10-15 show ':' as an error marker.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return ASCII_ZERO + {4'h0, digit};
        end
        return ASCII_ERROR;
    endfunction

endpackage

// File: rtl/alarm_ctrl.sv
// Alarm match register, ring/acknowledge/timeout state machine and ring-second counter.
module alarm_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned RING_SECS  = 60
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    one_second,
    input  logic                    alarm_enable,
    input  logic                    alarm_off,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic [4*NUM_DIGITS-1:0] alarm_time,
    output logic                    sound_alarm
);

    localparam int unsigned CW = $clog2(RING_SECS + 1);

    alarm_state_t   state_q;
    logic           match_q;
    logic [CW-1:0]  cnt_q;
    logic           sound_q;
    logic           match_c;
    logic           timeout_c;

    // Full-vector compare gated by the arm bit, and the tick that reaches the ring limit.
    always_comb begin
        match_c   = alarm_enable && (current_time == alarm_time);
        timeout_c = one_second && (cnt_q == CW'(RING_SECS - 1));
    end

    // Alarm FSM: ring on a fresh match, hold until the match period ends; disarm wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= A_IDLE;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sound_q <= 1'b0;
        end else begin
            match_q <= match_c;
            if (!alarm_enable) begin
                state_q <= A_IDLE;
                sound_q <= 1'b0;
            end else begin
                case (state_q)
                    A_IDLE: begin
                        if (match_c && !match_q) begin
                            state_q <= A_RING;
                            cnt_q   <= '0;
                            sound_q <= 1'b1;
                        end
                    end
                    A_RING: begin
                        if (alarm_off || timeout_c) begin
                            state_q <= A_HOLD;
                            sound_q <= 1'b0;
                        end else if (one_second && (cnt_q != CW'(RING_SECS))) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    A_HOLD: begin
                        if (!match_c) begin
                            state_q <= A_IDLE;
                        end
                    end
                    default: begin
                        state_q <= A_IDLE;
                        sound_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sound_alarm = sound_q;

endmodule

// File: rtl/display_driver_multi.sv
// Streams the selected BCD time value to the LCD as ASCII characters and drives the alarm output.
module display_driver_multi
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned RING_SECS  = 60
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    one_second,
    input  logic                    show_a,
    input  logic                    show_new_time,
    input  logic                    alarm_enable,
    input  logic                    alarm_off,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic [4*NUM_DIGITS-1:0] alarm_time,
    input  logic [4*NUM_DIGITS-1:0] key_buffer_time,
    input  logic                    char_ready,
    output logic                    char_valid,
    output logic [7:0]              char_data,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] char_pos,
    output logic                    frame_done,
    output logic                    sound_alarm
);

    localparam int unsigned W    = 4 * NUM_DIGITS;
    localparam int unsigned PW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned LAST = NUM_DIGITS - 1;

    frame_state_t   state_q;
    logic [W-1:0]   src_q;
    logic           blank_q;
    logic [PW-1:0]  pos_q;
    logic           valid_q;
    logic [7:0]     data_q;
    logic           done_q;
    logic           blink_q;

    logic [W-1:0]   src_c;
    logic           blank_c;
    logic [7:0]     first_char_c;
    logic [7:0]     nxt_char_c;
    logic [W-1:0]   shifted_c;
    int unsigned    nxt_idx_c;

    // Source priority and blanking decision sampled when a frame is loaded.
    always_comb begin
        src_c        = show_a ? alarm_time : (show_new_time ? key_buffer_time : current_time);
        blank_c      = show_new_time & ~show_a & ~blink_q;
        first_char_c = blank_c ? ASCII_BLANK : bcd_to_ascii(src_c[W-1 -: 4]);
    end

    // Character for the column after the current one, taken from the frame snapshot.
    always_comb begin
        nxt_idx_c = 0;
        if (32'(pos_q) < LAST) begin
            nxt_idx_c = LAST - 1 - 32'(pos_q);
        end
        shifted_c  = src_q >> (4 * nxt_idx_c);
        nxt_char_c = blank_q ? ASCII_BLANK : bcd_to_ascii(shifted_c[3:0]);
    end

    // Blink phase toggles each second in set mode and rests visible otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_q <= 1'b1;
        end else if (!show_new_time) begin
            blink_q <= 1'b1;
        end else if (one_second) begin
            blink_q <= ~blink_q;
        end
    end

    // Frame FSM: snapshot, send one char per accepted handshake, pulse frame_done, repeat.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= F_IDLE;
            src_q   <= '0;
            blank_q <= 1'b0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                F_IDLE: begin
                    state_q <= F_LOAD;
                end
                F_LOAD: begin
                    src_q   <= src_c;
                    blank_q <= blank_c;
                    pos_q   <= '0;
                    data_q  <= first_char_c;
                    valid_q <= 1'b1;
                    state_q <= F_SEND;
                end
                F_SEND: begin
                    if (char_ready) begin
                        if (pos_q == PW'(LAST)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= F_DONE;
                        end else begin
                            pos_q  <= pos_q + PW'(1);
                            data_q <= nxt_char_c;
                        end
                    end
                end
                F_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= F_LOAD;
                end
                default: begin
                    state_q <= F_IDLE;
                end
            endcase
        end
    end

    assign char_valid = valid_q;
    assign char_data  = data_q;
    assign char_pos   = pos_q;
    assign frame_done = done_q;

    alarm_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .RING_SECS  (RING_SECS)
    ) u_alarm_ctrl (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .alarm_enable (alarm_enable),
        .alarm_off    (alarm_off),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .sound_alarm  (sound_alarm)
    );

endmodule
